serial_addsub: RTL

// - Bit-serial two's-complement adder/subtractor, the sequential counterpart to the combinational full_add cell.
// - Accepts one WIDTH-bit operand pair per valid/ready handshake and processes it LSB-first through one full_add instance and a carry flop.
// - Returns sum, carry-out and signed overflow through an output valid/ready handshake.
// - Used where area matters more than latency. Serves as the datapath engine for later serial ALU work.

---
 rtl/serial_pkg.sv | 26 ++
 rtl/full_add.sv | 19 +
 rtl/serial_addsub.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial add/subtract datapath.
// - state_e : FSM encodings (IDLE, RUN, DONE)
// - clog2   : width of a counter that must hold 0..value-1 (minimum 1 bit)
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/full_add.sv
// Single-bit full adder cell; the one-bit datapath slice of the serial engine.
// Ports:
//   cin  in  carry in
//   a    in  operand A bit
//   b    in  operand B bit
//   s    out sum bit
//   cout out carry out
module full_add (
  input  logic cin,
  input  logic a,
  input  logic b,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor. One operand pair is accepted,
// processed LSB-first through a single full_add cell over WIDTH cycles, and the
// result is offered until the consumer takes it.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (a, b, sub)
//   a, b                WIDTH-bit operands
//   sub                 0: a+b, 1: a-b (a + ~b + 1)
//   out_valid/out_ready result handshake (sum, cout, ovf)
//   sum                 result modulo 2^WIDTH
//   cout                final carry (for subtract: 1 = no borrow)
//   ovf                 signed overflow
//   dbg_state           current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is high only in IDLE; out_valid is high only in DONE and
// stays high, with sum/cout/ovf stable, until out_ready is seen.
module serial_addsub
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int             CW       = clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s;
  logic             fa_cout;

  full_add u_full_add (
    .cin  (carry_q),
    .a    (op_a_q[0]),
    .b    (op_b_q[0]),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Subtraction folds into addition: invert B here, inject the +1 as carry-in.
          op_a_d     = a;
          op_b_d     = sub ? ~b : b;
          carry_d    = sub;
          cnt_d      = '0;
          sum_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_RUN;
        end
      end

      ST_RUN: begin
        // Result bits enter at the MSB so that after WIDTH shifts bit 0 is at the LSB.
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        op_a_d  = op_a_q >> 1;
        op_b_d  = op_b_q >> 1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // On the MSB slice, carry in vs. carry out differing means signed overflow.
          cout_d      = fa_cout;
          ovf_d       = fa_cout ^ carry_q;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule
